// File: rtl/osmlgd_pkg.sv
// Shared types and width helpers for the iterative one-step majority-logic decoder.
// Early exit is selected at build time with OSMLGD_EARLY_EXIT_EN.
package osmlgd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSynd,
    StFlip,
    StDone
  } osmlgd_state_e;

  // Unsatisfied-check counter width: at most M increments per pass.
  function automatic int unsigned cnt_width(input int unsigned m);
    return $clog2(m + 1);
  endfunction

  function automatic int unsigned row_width(input int unsigned m);
    return $clog2(m);
  endfunction

  function automatic int unsigned iter_width(input int unsigned max_iter);
    return $clog2(max_iter + 1);
  endfunction

endpackage

// File: rtl/osmlgd_row_check.sv
// Combinational check of one H row against the working codeword: parity bit plus
// the mask of codeword bits whose unsatisfied-check counters should increment.
module osmlgd_row_check #(
  parameter int unsigned N = 256
) (
  input  logic [N-1:0] row_i,
  input  logic [N-1:0] cw_i,
  output logic         s_o,
  output logic [N-1:0] inc_o
);

  always_comb begin
    s_o   = ^(row_i & cw_i);
    inc_o = row_i & {N{s_o}};
  end

endmodule

// File: rtl/osmlgd_iter.sv
// Iterative bit-flipping LDPC decoder with a runtime-writable H array.
// OSMLGD_EARLY_EXIT_EN: stop as soon as a pass sees a clean syndrome.
module osmlgd_iter
  import osmlgd_pkg::*;
#(
  parameter int unsigned N        = 256,
  parameter int unsigned M        = 128,
  parameter int unsigned MAX_ITER = 8,
  parameter int unsigned THR      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          work,
  input  logic [N-1:0]                  tx,
  input  logic                          h_we,
  input  logic [$clog2(M)-1:0]          h_addr,
  input  logic [N-1:0]                  h_row,
  output logic                          free,
  output logic [N-1:0]                  deout,
  output logic                          valid,
  output logic                          fail,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_cnt
);

  localparam int unsigned CntW  = cnt_width(M);
  localparam int unsigned RowW  = row_width(M);
  localparam int unsigned IterW = iter_width(MAX_ITER);

  osmlgd_state_e   state_q;
  logic [N-1:0]    h_q [M];
  logic [N-1:0]    cw_q;
  logic [CntW-1:0] cnt_q [N];
  logic [RowW-1:0] row_q;
  logic [IterW-1:0] iter_q;
  logic            any_q;
  logic            free_q;
  logic            valid_q;
  logic            fail_q;
  logic [N-1:0]    deout_q;
  logic [IterW-1:0] iter_out_q;

  logic            s;
  logic [N-1:0]    inc;
  logic [N-1:0]    flip;
  logic [N-1:0]    cw_flip;
  logic            last_pass;

  osmlgd_row_check #(
    .N(N)
  ) u_row_check (
    .row_i(h_q[row_q]),
    .cw_i (cw_q),
    .s_o  (s),
    .inc_o(inc)
  );

  always_comb begin
    flip = '0;
    for (int j = 0; j < N; j++) begin
      flip[j] = 32'(cnt_q[j]) > THR;
    end
    cw_flip = cw_q ^ flip;
  end

`ifdef OSMLGD_EARLY_EXIT_EN
  assign last_pass = !any_q || (iter_q == IterW'(MAX_ITER));
`else
  assign last_pass = (iter_q == IterW'(MAX_ITER));
`endif

  // H has no reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (free_q && h_we) begin
      h_q[h_addr] <= h_row;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cw_q       <= '0;
      row_q      <= '0;
      iter_q     <= '0;
      any_q      <= 1'b0;
      free_q     <= 1'b1;
      valid_q    <= 1'b0;
      fail_q     <= 1'b0;
      deout_q    <= '0;
      iter_out_q <= '0;
      for (int j = 0; j < N; j++) cnt_q[j] <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (work) begin
            cw_q    <= tx;
            row_q   <= '0;
            iter_q  <= IterW'(1);
            any_q   <= 1'b0;
            free_q  <= 1'b0;
            state_q <= StSynd;
            for (int j = 0; j < N; j++) cnt_q[j] <= '0;
          end
        end
        StSynd: begin
          if (s) begin
            any_q <= 1'b1;
            for (int j = 0; j < N; j++) cnt_q[j] <= cnt_q[j] + CntW'(inc[j]);
          end
          if (row_q == RowW'(M - 1)) begin
            state_q <= StFlip;
          end else begin
            row_q <= row_q + RowW'(1);
          end
        end
        StFlip: begin
          cw_q  <= cw_flip;
          row_q <= '0;
          for (int j = 0; j < N; j++) cnt_q[j] <= '0;
          if (last_pass) begin
            // Results are published on entry to DONE so they are stable with valid.
            deout_q    <= cw_flip;
            fail_q     <= any_q;
            iter_out_q <= iter_q;
            valid_q    <= 1'b1;
            state_q    <= StDone;
          end else begin
            iter_q  <= iter_q + IterW'(1);
            any_q   <= 1'b0;
            state_q <= StSynd;
          end
        end
        StDone: begin
          free_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign free     = free_q;
  assign valid    = valid_q;
  assign fail     = fail_q;
  assign deout    = deout_q;
  assign iter_cnt = iter_out_q;

endmodule

// File: tb/tb_osmlgd_iter.sv
// Randomised bench for osmlgd_iter against a pass-by-pass bit-flipping reference model.
module tb_osmlgd_iter;

  localparam int unsigned N        = 256;
  localparam int unsigned M        = 128;
  localparam int unsigned MAX_ITER = 8;
  localparam int unsigned THR      = 2;
  localparam int unsigned AW       = $clog2(M);
  localparam int unsigned IW       = $clog2(MAX_ITER + 1);
`ifdef OSMLGD_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          work;
  logic [N-1:0]  tx;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [N-1:0]  h_row;
  logic          free;
  logic [N-1:0]  deout;
  logic          valid;
  logic          fail;
  logic [IW-1:0] iter_cnt;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] h_ref [M];
  logic [N-1:0] h_cw4 [M];

  osmlgd_iter #(
    .N(N), .M(M), .MAX_ITER(MAX_ITER), .THR(THR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .work    (work),
    .tx      (tx),
    .h_we    (h_we),
    .h_addr  (h_addr),
    .h_row   (h_row),
    .free    (free),
    .deout   (deout),
    .valid   (valid),
    .fail    (fail),
    .iter_cnt(iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: repeated syndrome count + majority flip straight from the decoding rules.
  task automatic ref_decode(input logic [N-1:0] t, output logic [N-1:0] d, output int k,
                            output bit f);
    logic [N-1:0] cw;
    int cnt [N];
    bit any;
    cw = t;
    k  = 0;
    f  = 1'b0;
    for (int p = 1; p <= int'(MAX_ITER); p++) begin
      for (int j = 0; j < N; j++) cnt[j] = 0;
      any = 1'b0;
      for (int r = 0; r < M; r++) begin
        if (^(h_ref[r] & cw)) begin
          any = 1'b1;
          for (int j = 0; j < N; j++) if (h_ref[r][j]) cnt[j]++;
        end
      end
      for (int j = 0; j < N; j++) if (cnt[j] > int'(THR)) cw[j] = ~cw[j];
      k = p;
      f = any;
      if (!any && EarlyExit) break;
    end
    d = cw;
  endtask

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic write_row(input int r, input logic [N-1:0] v);
    h_we   = 1'b1;
    h_addr = AW'(r);
    h_row  = v;
    @(posedge clk);
    #1 h_we = 1'b0;
    h_ref[r] = v;
  endtask

  task automatic load_h(input bit zeros);
    for (int r = 0; r < M; r++) write_row(r, zeros ? '0 : h_cw4[r]);
  endtask

  // mode 0: plain, 1: work/h_we disturbance mid-decode, 2: reset at t0+50,
  // 3: row-0 write to all ones in the same cycle as work.
  task automatic decode(input logic [N-1:0] t, input string tag, input int mode);
    logic [N-1:0] exp_d;
    int exp_k;
    bit exp_f;
    int n;
    bit seen;
    if (mode == 3) begin
      h_ref[0] = '1;
      h_we     = 1'b1;
      h_addr   = '0;
      h_row    = '1;
    end
    ref_decode(t, exp_d, exp_k, exp_f);
    tx   = t;
    work = 1'b1;
    @(posedge clk);
    #1 work = 1'b0;
    h_we = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 3000) begin
      if (mode == 1 && n == 20) begin
        work   = 1'b1;
        tx     = ~t;
        h_we   = 1'b1;
        h_addr = '0;
        h_row  = '1;
      end else if (mode == 1 && n == 21) begin
        work = 1'b0;
        h_we = 1'b0;
      end
      if (mode == 2 && n == 49) rst = 1'b0;
      @(posedge clk);
      #1 n++;
      if (mode == 2 && n == 50) begin
        rst = 1'b1;
        check_eq({tag, "/rst_free"}, N'(free), N'(1));
        check_eq({tag, "/rst_valid"}, N'(valid), N'(0));
        check_eq({tag, "/rst_deout"}, deout, '0);
        check_eq({tag, "/rst_iter"}, N'(iter_cnt), N'(0));
        check_eq({tag, "/rst_fail"}, N'(fail), N'(0));
        return;
      end
      seen = valid;
    end
    check_eq({tag, "/latency"}, N'(n), N'(exp_k * int'(M + 1)));
    check_eq({tag, "/deout"}, deout, exp_d);
    check_eq({tag, "/iter"}, N'(iter_cnt), N'(exp_k));
    check_eq({tag, "/fail"}, N'(fail), N'(exp_f));
    check_eq({tag, "/busy"}, N'(free), N'(0));
    @(posedge clk);
    #1;
    check_eq({tag, "/pulse"}, N'(valid), N'(0));
    check_eq({tag, "/free"}, N'(free), N'(1));
    check_eq({tag, "/hold"}, deout, exp_d);
  endtask

  initial begin
    logic [N-1:0] t;
    logic [7:0]   jb;
    logic [N-1:0] d;
    int k;
    bit f;

    // Column-weight-4 H: any two distinct columns share at most two rows.
    for (int r = 0; r < M; r++) h_cw4[r] = '0;
    for (int j = 0; j < N; j++) begin
      jb = 8'(j);
      h_cw4[jb[4:0]][j]                                       = 1'b1;
      h_cw4[32 + int'(jb[7:3])][j]                            = 1'b1;
      h_cw4[64 + int'({jb[7:5], jb[1:0]})][j]                 = 1'b1;
      h_cw4[96 + int'(jb[4:0] ^ {jb[7:5], jb[7:6]})][j]       = 1'b1;
    end

    rst = 1'b0; work = 1'b0; tx = '0; h_we = 1'b0; h_addr = '0; h_row = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset/free", N'(free), N'(1));
    check_eq("reset/valid", N'(valid), N'(0));
    check_eq("reset/deout", deout, '0);
    check_eq("reset/fail", N'(fail), N'(0));
    check_eq("reset/iter", N'(iter_cnt), N'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    load_h(1'b1);
    t = {8{$urandom()}};
    decode(t, "zero_h", 0);
    check_eq("zero_h/passthru", deout, t);

    load_h(1'b0);
    t = '0;
    t[5] = 1'b1;
    decode(t, "bit5", 0);
    check_eq("bit5/corrected", deout, '0);

    t = '0;
    t[7:0] = 8'hff;
    decode(t, "uncorr", 0);
    check_eq("uncorr/iter_max", N'(iter_cnt), N'(MAX_ITER));
    check_eq("uncorr/fail", N'(fail), N'(1));

    for (int i = 0; i < 3; i++) begin
      t = '0;
      for (int e = 0; e < int'($urandom_range(1, 3)); e++) t[$urandom_range(N - 1, 0)] = 1'b1;
      decode(t, "rand_err", 0);
    end
    t = {8{$urandom()}};
    decode(t, "rand_word", 0);

    t = '0;
    t[5] = 1'b1;
    t[200] = 1'b1;
    decode(t, "disturb", 1);
    decode(t, "idle_write", 3);
    ref_decode(t, d, k, f);
    write_row(0, h_cw4[0]);

    t = '0;
    t[77] = 1'b1;
    decode(t, "abandon", 2);
    decode(t, "after_rst", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
